// File: rtl/wb_regfile.sv
// wb_regfile: writeback stage and 16 x 16-bit architectural register file.
//   Selects the writeback value (link address, memory data or ALU result),
//   commits it to the array, serves two combinational read ports with
//   same-cycle write bypass, tracks the RUN/HALTED state and counts retired
//   instructions (saturating).
// Ports:
//   clk, rst (async, active-low)
//   valid_in, RegWrite, MemtoReg, PCtoReg, Halt : MEM/WB control
//   reg_data_in, dmem_in, pc_in, DstReg_in      : MEM/WB data
//   SrcReg1/2 -> SrcData1/2                     : decode read ports (bypassed)
//   wb_en, wb_dst, wb_data                      : to the forwarding unit
//   halted, retired                             : core status
module wb_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        RegWrite,
  input  logic        MemtoReg,
  input  logic        PCtoReg,
  input  logic        Halt,
  input  logic [15:0] reg_data_in,
  input  logic [15:0] dmem_in,
  input  logic [15:0] pc_in,
  input  logic [3:0]  DstReg_in,
  input  logic [3:0]  SrcReg1,
  input  logic [3:0]  SrcReg2,
  output logic [15:0] SrcData1,
  output logic [15:0] SrcData2,
  output logic        wb_en,
  output logic [3:0]  wb_dst,
  output logic [15:0] wb_data,
  output logic        halted,
  output logic [15:0] retired
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_regs [16];
  logic [15:0] r_retired;
  logic [15:0] w_wb_data;
  logic        w_wb_en;
  logic        w_run;

  assign w_run = (r_state == RUN);

  // Writeback mux: link address beats memory data beats ALU result.
  always_comb begin
    w_wb_data = reg_data_in;
    if (PCtoReg)
      w_wb_data = pc_in;
    else if (MemtoReg)
      w_wb_data = dmem_in;
  end

  // R0 is excluded here so it can never be written nor bypassed from.
  assign w_wb_en = valid_in & RegWrite & ~Halt & (DstReg_in != 4'd0) & w_run;

  always_comb begin
    w_state_nxt = r_state;
    if (w_run && valid_in && Halt)
      w_state_nxt = HALTED;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= RUN;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 16; i++)
        r_regs[i] <= '0;
    end else if (w_wb_en) begin
      r_regs[DstReg_in] <= w_wb_data;
    end
  end

  // The HLT itself counts because the count is taken while still in RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_retired <= '0;
    else if (w_run && valid_in && (r_retired != 16'hFFFF))
      r_retired <= r_retired + 16'd1;
  end

  always_comb begin
    SrcData1 = r_regs[SrcReg1];
    if (SrcReg1 == 4'd0)
      SrcData1 = '0;
    else if (w_wb_en && (SrcReg1 == DstReg_in))
      SrcData1 = w_wb_data;
  end

  always_comb begin
    SrcData2 = r_regs[SrcReg2];
    if (SrcReg2 == 4'd0)
      SrcData2 = '0;
    else if (w_wb_en && (SrcReg2 == DstReg_in))
      SrcData2 = w_wb_data;
  end

  assign wb_en   = w_wb_en;
  assign wb_dst  = DstReg_in;
  assign wb_data = w_wb_data;
  assign halted  = (r_state == HALTED);
  assign retired = r_retired;

endmodule
